seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Downstream display stage for the stopwatch top: takes the six 7-segment patterns (m10, m1, s10, s1, s01, s001) and time-multiplexes them onto one shared segment bus with six digit-common enables.
- Board display is a 6-digit common-bus module, so only one digit is lit per scan slot.
- Adds decimal points, inter-digit ghost blanking and per-frame snapshotting, so a digit rollover never tears within a frame.

Parameters:
- SCAN_DIV, 1000, clk cycles per digit slot; legal range is >= 2.
- BLANK_CYCLES, 2, cycles at the start of each slot with all commons inactive; legal range is 1 .. SCAN_DIV-1.
- DP_MASK, 6'b001010, per-digit decimal point enable, indexed by digit index; default lights dp after m1 and s1.
- SEG_ACTIVE_LOW, 0, 1 inverts all 8 seg_data bits at the output.
- COM_ACTIVE_LOW, 1, 1 makes the selected common 0 and the idle commons 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- blank  input  1  1 forces all commons inactive and segments off, sampled every cycle
- m10  input  7  digit index 0 pattern (leftmost); bit=1 means segment lit; bits [6:0] are passed through unchanged
- m1  input  7  digit index 1 pattern
- s10  input  7  digit index 2 pattern
- s1  input  7  digit index 3 pattern
- s01  input  7  digit index 4 pattern
- s001  input  7  digit index 5 pattern (rightmost)
- seg_data  output  8  [7]=dp, [6:0]=segment pattern of the selected digit, after polarity
- seg_com  output  6  digit commons; bit i selects digit index i, after polarity

Behaviour:
- State registers:
  - div_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - idx is 0..5; it increments when div_cnt wraps, and 5 wraps to 0.
  - snap[0..5] holds six 7-bit snapshots.
- Snapshot load:
  - snap loads all six inputs simultaneously in any cycle where idx==0 and div_cnt==0.
  - This includes the first clock after reset release.
  - Input changes at any other time are invisible until the next frame start.
- Outputs are registered, 1-cycle latency from state. The values at cycle t+1 are computed from idx, div_cnt, blank and snap at cycle t.
- Active condition: active = !blank && div_cnt >= BLANK_CYCLES.
  - If active: seg_com is one-hot on bit idx; seg_data = {DP_MASK[idx], snap[idx]}.
  - If not active: seg_com = 6'b000000 and seg_data = 8'h00 (logical values before polarity).
- Polarity: logical values are inverted per SEG_ACTIVE_LOW / COM_ACTIVE_LOW before the output registers, so inactive levels hold during reset.
- Frame timing: one frame is 6*SCAN_DIV cycles. Each digit is lit for SCAN_DIV-BLANK_CYCLES consecutive cycles. Adjacent digits never have overlapping commons; there are at least BLANK_CYCLES all-off cycles between them.
- blank does not stop div_cnt or idx; scanning continues invisibly. When blank deasserts, output resumes on the current slot, obeying the blanking window.
- Reset (async assert, any time including mid-slot):
  - div_cnt=0, idx=0, snap all 0.
  - seg_data = logical 8'h00 (8'hFF if SEG_ACTIVE_LOW).
  - seg_com = logical 6'h00 (6'h3F if COM_ACTIVE_LOW).
  - On release, scanning restarts at idx 0 with a fresh snapshot; no partial slot is carried over.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset values, defaults: hold rst=0 -> seg_data=8'h00, seg_com=6'h3F. Release rst -> first 3 output cycles remain seg_com=6'h3F; cycle 4 (div_cnt=2 registered) shows seg_com=6'b111110.
2. Scan order, SCAN_DIV=4, BLANK_CYCLES=1, COM_ACTIVE_LOW=0, inputs m10=7'h01 .. s001=7'h06 constant:
   - Each 4-cycle slot has 1 cycle with seg_com=0, then 3 cycles with seg_com=1<<i.
   - seg_data[6:0]=i+1, with dp set on idx 1 and 3 only.
   - After idx 5, idx 0 follows.
3. Snapshot coherence: change s1 from 7'h3F to 7'h06 while idx==2. Digit 3 must still show 7'h3F in the current frame and 7'h06 from the next frame onward.
4. blank: assert blank for 10 cycles mid-slot -> seg_com all inactive, seg_data off. Deassert mid-slot -> the same idx resumes and timing is unchanged versus a run without blank.
5. Mid-scan reset: assert rst during idx 4 -> outputs go inactive asynchronously (same cycle). Release -> the sequence restarts at idx 0 and snap reflects the inputs at release.
6. Polarity: SEG_ACTIVE_LOW=1 with m10=7'h7F -> during digit 0 active, seg_data=8'h80 (dp off inverted, segments on inverted); during the blank window, seg_data=8'hFF.

Source files
------------

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - six-digit multiplexed 7-segment scan driver with per-frame snapshot
// Only one digit common is enabled at a time, with an all-off window at the start of each slot.
module seg_scan_driver #(
    parameter int          SCAN_DIV       = 1000,
    parameter int          BLANK_CYCLES   = 2,
    parameter logic [5:0]  DP_MASK        = 6'b001010,
    parameter int          SEG_ACTIVE_LOW = 0,
    parameter int          COM_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       blank,
    input  logic [6:0] m10,
    input  logic [6:0] m1,
    input  logic [6:0] s10,
    input  logic [6:0] s1,
    input  logic [6:0] s01,
    input  logic [6:0] s001,
    output logic [7:0] seg_data,
    output logic [5:0] seg_com
);

    localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_C  = CW'(BLANK_CYCLES);
    localparam logic [7:0]    SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [5:0]    COM_OFF  = (COM_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

    logic [CW-1:0] div_cnt;
    logic [2:0]    idx;
    logic [6:0]    snap [6];
    logic          div_wrap;
    logic          frame_start;
    logic          active;
    logic [7:0]    seg_logic;
    logic [5:0]    com_logic;
    logic [7:0]    seg_next;
    logic [5:0]    com_next;

    assign div_wrap    = (div_cnt == DIV_LAST);
    assign frame_start = (idx == 3'd0) && (div_cnt == '0);

    always_comb begin
        seg_logic = 8'h00;
        com_logic = 6'h00;
        active    = !blank && (div_cnt >= BLANK_C);
        if (active) begin
            com_logic = 6'b000001 << idx;
            seg_logic = {DP_MASK[idx], snap[idx]};
        end
        seg_next = (SEG_ACTIVE_LOW != 0) ? ~seg_logic : seg_logic;
        com_next = (COM_ACTIVE_LOW != 0) ? ~com_logic : com_logic;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt  <= '0;
            idx      <= 3'd0;
            for (int i = 0; i < 6; i++) begin
                snap[i] <= 7'h00;
            end
            seg_data <= SEG_OFF;
            seg_com  <= COM_OFF;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + CW'(1);
            if (div_wrap) begin
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end
            // Capture all digits together so a rollover never tears within a frame
            if (frame_start) begin
                snap[0] <= m10;
                snap[1] <= m1;
                snap[2] <= s10;
                snap[3] <= s1;
                snap[4] <= s01;
                snap[5] <= s001;
            end
            seg_data <= seg_next;
            seg_com  <= com_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - scoreboard bench for seg_scan_driver
module tb_seg_scan_driver;

    localparam logic [5:0] DP = 6'b001010;

    logic       clk = 1'b0;
    logic       rst;
    logic       blank;
    logic [6:0] dg [6];
    logic [7:0] a_data, b_data, c_data;
    logic [5:0] a_com,  b_com,  c_com;

    always #5 clk = ~clk;

    seg_scan_driver #(.SCAN_DIV(4), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(0), .COM_ACTIVE_LOW(0)) u_a (
        .clk(clk), .rst(rst), .blank(blank),
        .m10(dg[0]), .m1(dg[1]), .s10(dg[2]), .s1(dg[3]), .s01(dg[4]), .s001(dg[5]),
        .seg_data(a_data), .seg_com(a_com)
    );

    seg_scan_driver u_b (
        .clk(clk), .rst(rst), .blank(blank),
        .m10(dg[0]), .m1(dg[1]), .s10(dg[2]), .s1(dg[3]), .s01(dg[4]), .s001(dg[5]),
        .seg_data(b_data), .seg_com(b_com)
    );

    seg_scan_driver #(.SCAN_DIV(4), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(1), .COM_ACTIVE_LOW(1)) u_c (
        .clk(clk), .rst(rst), .blank(blank),
        .m10(dg[0]), .m1(dg[1]), .s10(dg[2]), .s1(dg[3]), .s01(dg[4]), .s001(dg[5]),
        .seg_data(c_data), .seg_com(c_com)
    );

    typedef struct {
        int         stamp;
        logic [7:0] ad;
        logic [5:0] ac;
        logic [7:0] bd;
        logic [5:0] bc;
        logic [7:0] cd;
        logic [5:0] cc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          n = 0;
    logic [41:0] sa = '0;
    logic [41:0] sb = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected logical {seg_data, seg_com} for scan position nn (cycles since release)
    function automatic logic [13:0] mdl(int nn, int sd, int bc, logic blk, logic [41:0] sn);
        logic [13:0] r;
        int dv;
        int ix;
        r  = '0;
        dv = nn % sd;
        ix = (nn / sd) % 6;
        if (!blk && dv >= bc) begin
            r[5:0]  = 6'b000001 << ix;
            r[13:6] = {DP[ix], sn[ix*7 +: 7]};
        end
        return r;
    endfunction

    task automatic chk(string nm, logic [7:0] gd, logic [7:0] wd, logic [5:0] gc, logic [5:0] wc);
        total++;
        if ({gd, gc} !== {wd, wc}) begin
            bad++;
            $display("FAIL %s cyc=%0d got data=%h com=%h want data=%h com=%h", nm, cyc, gd, gc, wd, wc);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].stamp <= cyc) begin
                e = q.pop_front();
                if (e.stamp != cyc) begin
                    total++;
                    bad++;
                    $display("FAIL stale cyc=%0d got stamp=%0d want stamp=%0d", cyc, e.stamp, cyc);
                end else begin
                    chk("dut_a", a_data, e.ad, a_com, e.ac);
                    chk("dut_b", b_data, e.bd, b_com, e.bc);
                    chk("dut_c", c_data, e.cd, c_com, e.cc);
                end
            end
        end
    end

    task automatic step();
        exp_t        e;
        logic [13:0] ea;
        logic [13:0] eb;
        logic [41:0] cur;
        cur = {dg[5], dg[4], dg[3], dg[2], dg[1], dg[0]};
        if (!rst) begin
            ea = '0;
            eb = '0;
            n  = 0;
            sa = '0;
            sb = '0;
        end else begin
            ea = mdl(n, 4, 1, blank, sa);
            eb = mdl(n, 1000, 2, blank, sb);
            if (n % 24 == 0)   sa = cur;
            if (n % 6000 == 0) sb = cur;
            n++;
        end
        e.stamp = cyc + 1;
        e.ad = ea[13:6];
        e.ac = ea[5:0];
        e.bd = eb[13:6];
        e.bc = ~eb[5:0];
        e.cd = ~ea[13:6];
        e.cc = ~ea[5:0];
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run(int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic run_until(int t);
        while (n < t) step();
    endtask

    // Reset lands between edges; this cycle's outputs must already be inactive
    task automatic async_reset();
        exp_t e;
        rst = 1'b0;
        e = q.pop_back();
        e.stamp = cyc;
        e.ad = 8'h00;
        e.ac = 6'h00;
        e.bd = 8'h00;
        e.bc = 6'h3F;
        e.cd = 8'hFF;
        e.cc = 6'h3F;
        q.push_back(e);
    endtask

    initial begin
        rst   = 1'b0;
        blank = 1'b0;
        for (int i = 0; i < 6; i++) dg[i] = 7'(i + 1);
        @(posedge clk);
        #1;
        run(3);
        rst = 1'b1;
        run(30);
        dg[3] = 7'h3F;
        run_until(58);
        dg[3] = 7'h06;
        run_until(101);
        blank = 1'b1;
        run(10);
        blank = 1'b0;
        dg[0] = 7'h7F;
        run_until(161);
        async_reset();
        run(2);
        for (int i = 0; i < 6; i++) dg[i] = 7'(7'h40 + i);
        rst = 1'b1;
        run(30);
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want pending=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
